// File: rtl/seq_addsub.sv
// seq_addsub
//   Chunk-serial two's-complement adder/subtractor. It adds CHUNK bits per
//   clock, so an operation takes N = WIDTH/CHUNK clocks from the accepting
//   edge to the done pulse. The result can optionally saturate on signed
//   overflow, and it is sign-extended to OUT_WIDTH bits.
//
// Parameters
//   WIDTH      operand width (>= 2)
//   CHUNK      bits processed per clock (must divide WIDTH)
//   OUT_WIDTH  result width (>= WIDTH)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     request, sampled only when not busy
//   mode      bit0 = subtract (A-B), bit1 = saturate on overflow
//   inputA    signed operand A
//   inputB    signed operand B
//   busy      operation in progress
//   done      one-cycle pulse when the result registers update
//   sum       registered result, sign-extended from bit WIDTH-1
//   carry     carry out of the MSB (in subtract mode, 1 = no borrow)
//   overflow  signed overflow of the unsaturated arithmetic
module seq_addsub #(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 4,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     inputA,
  input  logic [WIDTH-1:0]     inputB,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] sum,
  output logic                 carry,
  output logic                 overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST_CHUNK = CW'(N - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS   = ~MOST_NEG;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        count_q;
  logic [WIDTH-1:0]     opA_q;
  logic [WIDTH-1:0]     opB_q;
  logic [WIDTH-1:0]     acc_q;
  logic                 carry_q;
  logic                 sat_q;
  logic                 aMsb_q;
  logic                 bMsb_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 carryOut_q;
  logic                 overflow_q;
  logic [OUT_WIDTH-1:0] sum_q;

  logic [CHUNK:0]       chunkSum_d;
  logic [WIDTH-1:0]     acc_d;
  logic [WIDTH-1:0]     result_d;
  logic [OUT_WIDTH-1:0] sumExt_d;
  logic                 carryOut_d;
  logic                 overflow_d;

  // The operand registers shift right by CHUNK every RUN cycle, so the
  // current chunk is always in the low bits and no variable indexing is
  // needed. The accumulator shifts the same way with each new chunk entering
  // at the top; after N cycles the first chunk has reached bit 0.
  // The carry into the MSB is recovered from the MSB sum bit
  // (a ^ b ^ cin = s), which lets overflow be formed without tracking the
  // intermediate carry inside the last chunk.
  always_comb begin
    chunkSum_d = {1'b0, opA_q[CHUNK-1:0]} + {1'b0, opB_q[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_q};
    acc_d      = (acc_q >> CHUNK)
                 | (WIDTH'(chunkSum_d[CHUNK-1:0]) << (WIDTH - CHUNK));
    carryOut_d = chunkSum_d[CHUNK];
    overflow_d = aMsb_q ^ bMsb_q ^ acc_d[WIDTH-1] ^ carryOut_d;
    result_d   = acc_d;
    if (sat_q && overflow_d) begin
      result_d = aMsb_q ? MOST_NEG : MOST_POS;
    end
    sumExt_d   = OUT_WIDTH'($signed(result_d));
  end

  // Control FSM and datapath registers. A request is accepted in IDLE or in
  // DONE, which allows back-to-back operations while done still pulses
  // exactly once per completed operation. The result registers change only
  // on the last chunk, so they hold their values through IDLE and through
  // the RUN cycles of the next operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      sat_q      <= 1'b0;
      aMsb_q     <= 1'b0;
      bMsb_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, with the +1 entering as carry-in.
            opA_q   <= inputA;
            opB_q   <= inputB ^ {WIDTH{mode[0]}};
            aMsb_q  <= inputA[WIDTH-1];
            bMsb_q  <= inputB[WIDTH-1] ^ mode[0];
            carry_q <= mode[0];
            sat_q   <= mode[1];
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          opA_q   <= opA_q >> CHUNK;
          opB_q   <= opB_q >> CHUNK;
          acc_q   <= acc_d;
          carry_q <= carryOut_d;
          if (count_q == LAST_CHUNK) begin
            sum_q      <= sumExt_d;
            carryOut_q <= carryOut_d;
            overflow_q <= overflow_d;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            count_q    <= '0;
            state_q    <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carry    = carryOut_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub
//   Directed, table-driven bench for seq_addsub at default parameters
//   (WIDTH=16, CHUNK=4, OUT_WIDTH=32), plus hand-written sequences for the
//   handshake, back-to-back and mid-operation reset cases.
module tb_seq_addsub;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] inputA;
  logic [15:0] inputB;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        carry;
  logic        overflow;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] expSum;
    logic        expCarry;
    logic        expOvf;
  } vec_t;

  vec_t vecs[13];

  seq_addsub #(
    .WIDTH(16),
    .CHUNK(4),
    .OUT_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .inputA(inputA),
    .inputB(inputB),
    .busy(busy),
    .done(done),
    .sum(sum),
    .carry(carry),
    .overflow(overflow)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Wait (bounded) until done is seen at a falling edge. Called at the
  // falling edge just after the accepting edge; lat counts rising edges
  // from there, busyCnt counts falling-edge samples with busy high.
  task automatic waitDone(output int lat, output int busyCnt);
    lat = 0;
    busyCnt = 0;
    while (!done && lat < 20) begin
      if (busy) busyCnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one operation and wait for it to finish. With immediate=1 the
  // request is driven in the current cycle (used from the DONE cycle);
  // otherwise one more cycle passes first. Inputs are scrambled after the
  // accepting edge because only the sampled values may matter.
  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] a,
                               input logic [15:0] b, input bit immediate,
                               output int lat, output int busyCnt);
    if (!immediate) @(negedge clk);
    start  = 1'b1;
    mode   = m;
    inputA = a;
    inputB = b;
    @(negedge clk);
    start  = 1'b0;
    mode   = ~m;
    inputA = 16'hDEAD;
    inputB = 16'hBEEF;
    waitDone(lat, busyCnt);
  endtask

  initial begin
    int lat;
    int busyCnt;
    int doneSeen;

    checks = 0;
    errors = 0;

    vecs[0]  = '{"add_small",   2'b00, 16'h0002, 16'h0002, 32'h00000004, 1'b0, 1'b0};
    vecs[1]  = '{"add_wrap",    2'b00, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[2]  = '{"sub_neg",     2'b01, 16'h0000, 16'h000E, 32'hFFFFFFF2, 1'b0, 1'b0};
    vecs[3]  = '{"sub_pos",     2'b01, 16'h000C, 16'h0007, 32'h00000005, 1'b1, 1'b0};
    vecs[4]  = '{"add_ovf",     2'b00, 16'h7FFF, 16'h0001, 32'hFFFF8000, 1'b0, 1'b1};
    vecs[5]  = '{"add_sat_pos", 2'b10, 16'h7FFF, 16'h0001, 32'h00007FFF, 1'b0, 1'b1};
    vecs[6]  = '{"sub_sat_neg", 2'b11, 16'h8000, 16'h0001, 32'hFFFF8000, 1'b1, 1'b1};
    vecs[7]  = '{"add_mixed",   2'b00, 16'h1234, 16'h4321, 32'h00005555, 1'b0, 1'b0};
    vecs[8]  = '{"sub_equal",   2'b01, 16'h8000, 16'h8000, 32'h00000000, 1'b1, 1'b0};
    vecs[9]  = '{"sub_sat_pos", 2'b11, 16'h7FFF, 16'hFFFF, 32'h00007FFF, 1'b0, 1'b1};
    vecs[10] = '{"add_neg_ovf", 2'b00, 16'h8000, 16'h8000, 32'h00000000, 1'b1, 1'b1};
    vecs[11] = '{"add_sat_neg", 2'b10, 16'h8000, 16'h8000, 32'hFFFF8000, 1'b1, 1'b1};
    vecs[12] = '{"add_ripple",  2'b00, 16'h0F0F, 16'h00F1, 32'h00001000, 1'b0, 1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    mode   = 2'b00;
    inputA = '0;
    inputB = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",     32'(busy),     32'd0);
    checkOutput("reset_done",     32'(done),     32'd0);
    checkOutput("reset_sum",      sum,           32'd0);
    checkOutput("reset_carry",    32'(carry),    32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, 1'b0, lat, busyCnt);
      checkOutput({vecs[i].name, "_latency"},  32'(lat),      32'd4);
      checkOutput({vecs[i].name, "_busycnt"},  32'(busyCnt),  32'd4);
      checkOutput({vecs[i].name, "_busy"},     32'(busy),     32'd0);
      checkOutput({vecs[i].name, "_sum"},      sum,           vecs[i].expSum);
      checkOutput({vecs[i].name, "_carry"},    32'(carry),    32'(vecs[i].expCarry));
      checkOutput({vecs[i].name, "_overflow"}, 32'(overflow), 32'(vecs[i].expOvf));
    end

    // Start during RUN is ignored; results also hold during the new RUN.
    // The previous result is 0x00001000 from the last table entry.
    @(negedge clk);
    start  = 1'b1;
    mode   = 2'b00;
    inputA = 16'h0002;
    inputB = 16'h0002;
    @(negedge clk);
    mode   = 2'b10;
    inputA = 16'h7FFF;
    inputB = 16'h0001;
    checkOutput("hold_sum_in_run", sum,        32'h00001000);
    checkOutput("hold_busy_in_run", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, busyCnt);
    // One edge of the four has already passed before waitDone started.
    checkOutput("ignore_latency",  32'(lat),      32'd3);
    checkOutput("ignore_sum",      sum,           32'h00000004);
    checkOutput("ignore_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_sum",  sum,       32'h00000004);

    // Back-to-back: second request issued in the DONE cycle.
    applyStimulus(2'b01, 16'h000C, 16'h0007, 1'b0, lat, busyCnt);
    checkOutput("b2b_first_done", 32'(done), 32'd1);
    checkOutput("b2b_first_sum",  sum,       32'h00000005);
    applyStimulus(2'b00, 16'h7FFF, 16'h0001, 1'b1, lat, busyCnt);
    checkOutput("b2b_second_latency",  32'(lat),      32'd4);
    checkOutput("b2b_second_busycnt",  32'(busyCnt),  32'd4);
    checkOutput("b2b_second_sum",      sum,           32'hFFFF8000);
    checkOutput("b2b_second_overflow", 32'(overflow), 32'd1);

    // Reset after the second chunk edge of a RUN.
    @(negedge clk);
    start  = 1'b1;
    mode   = 2'b00;
    inputA = 16'h1234;
    inputB = 16'h4321;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_busy",     32'(busy),     32'd0);
    checkOutput("midreset_done",     32'(done),     32'd0);
    checkOutput("midreset_sum",      sum,           32'd0);
    checkOutput("midreset_carry",    32'(carry),    32'd0);
    checkOutput("midreset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkOutput("midreset_no_activity", 32'(doneSeen), 32'd0);

    applyStimulus(2'b01, 16'h000C, 16'h0007, 1'b0, lat, busyCnt);
    checkOutput("after_reset_latency", 32'(lat),   32'd4);
    checkOutput("after_reset_sum",     sum,        32'h00000005);
    checkOutput("after_reset_carry",   32'(carry), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
